fifo_wr_arbiter: RTL and testbench

- Round-robin write arbiter that shares one 8-deep byte FIFO between N producer ports.
- Sits directly in front of the FIFO. It drives the FIFO's wr/data_in, and watches fifo_cnt/full to prevent overflow.
- Supports bounded bursts, so one producer can stream up to BURST consecutive bytes before the grant rotates.

---
 rtl/fifo_wr_arbiter.sv | 177 +++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter feeding one shared byte FIFO from N producers.
// Grants bounded bursts of up to BURST beats and never overflows the FIFO,
// counting the beat still in flight on fifo_wr as already occupying a slot.
module fifo_wr_arbiter #(
  parameter int N     = 4,
  parameter int BURST = 4,
  parameter int DEPTH = 8
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [N-1:0]   req,
  input  logic [8*N-1:0] req_data,
  output logic [N-1:0]   ack,
  input  logic [3:0]     fifo_cnt,
  input  logic           fifo_full,
  output logic           fifo_wr,
  output logic [7:0]     fifo_data,
  output logic [2:0]     grant_id,
  output logic           busy
);

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  state_t      state_q, state_d;
  logic [2:0]  rr_ptr_q, rr_ptr_d;
  logic [2:0]  grant_id_q, grant_id_d;
  logic [3:0]  beat_cnt_q, beat_cnt_d;
  logic        busy_q, busy_d;
  logic        fifo_wr_q, fifo_wr_d;
  logic [7:0]  fifo_data_q, fifo_data_d;
  logic [N-1:0] ack_d;

  logic [4:0]  occ_sum;
  logic        space;
  logic        rr_found;
  logic [2:0]  rr_sel;
  logic [7:0]  sel_data;
  logic        owner_req;
  logic [7:0]  owner_data;
  logic [7:0]  port_byte [N];

  // Next port index with wrap from N-1 back to 0.
  function automatic logic [2:0] wrap_inc(input logic [2:0] idx);
    if (idx == 3'(N-1)) return 3'd0;
    return idx + 3'd1;
  endfunction

  // (base + off) mod N, with off in 0..N-1.
  function automatic logic [2:0] wrap_add(input logic [2:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return 3'(s);
  endfunction

  // Split the packed data bus into one byte per port.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_port
      assign port_byte[gi] = req_data[8*gi +: 8];
    end
  endgenerate

  // The beat on fifo_wr is not yet visible in fifo_cnt, so count it here.
  assign occ_sum = {1'b0, fifo_cnt} + {4'd0, fifo_wr_q};
  assign space   = (occ_sum < 5'(DEPTH)) && !fifo_full;

  // First requesting port found when searching upward from rr_ptr.
  always_comb begin
    rr_found = 1'b0;
    rr_sel   = 3'd0;
    for (int k = N - 1; k >= 0; k--) begin
      for (int i = 0; i < N; i++) begin
        if (req[i] && (wrap_add(rr_ptr_q, k) == 3'(i))) begin
          rr_found = 1'b1;
          rr_sel   = 3'(i);
        end
      end
    end
  end

  // Data of the round-robin winner, and request/data of the burst owner.
  always_comb begin
    sel_data   = 8'd0;
    owner_req  = 1'b0;
    owner_data = 8'd0;
    for (int i = 0; i < N; i++) begin
      if (rr_sel == 3'(i)) sel_data = port_byte[i];
      if (grant_id_q == 3'(i)) begin
        owner_req  = req[i];
        owner_data = port_byte[i];
      end
    end
  end

  // Arbitration FSM next-state, ack and write-beat decode.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    beat_cnt_d  = beat_cnt_q;
    busy_d      = busy_q;
    fifo_wr_d   = 1'b0;
    fifo_data_d = fifo_data_q;
    ack_d       = '0;
    case (state_q)
      ST_IDLE: begin
        if (space && rr_found) begin
          ack_d       = ONE_HOT0 << rr_sel;
          fifo_wr_d   = 1'b1;
          fifo_data_d = sel_data;
          grant_id_d  = rr_sel;
          beat_cnt_d  = 4'd1;
          if (BURST > 1) begin
            state_d = ST_BURST;
            busy_d  = 1'b1;
          end else begin
            rr_ptr_d = wrap_inc(rr_sel);
          end
        end
      end
      ST_BURST: begin
        if (owner_req) begin
          // Without space the owner simply waits; the burst is kept intact.
          if (space) begin
            ack_d       = ONE_HOT0 << grant_id_q;
            fifo_wr_d   = 1'b1;
            fifo_data_d = owner_data;
            beat_cnt_d  = beat_cnt_q + 4'd1;
            if ((beat_cnt_q + 4'd1) == 4'(BURST)) begin
              rr_ptr_d = wrap_inc(grant_id_q);
              state_d  = ST_IDLE;
              busy_d   = 1'b0;
            end
          end
        end else begin
          // Owner stopped early: give up the grant, costing one idle cycle.
          rr_ptr_d = wrap_inc(grant_id_q);
          state_d  = ST_IDLE;
          busy_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Ack is suppressed during reset so no producer drops a byte.
  assign ack = rstn ? ack_d : '0;

  // State and registered output update.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= 3'd0;
      grant_id_q  <= 3'd0;
      beat_cnt_q  <= 4'd0;
      busy_q      <= 1'b0;
      fifo_wr_q   <= 1'b0;
      fifo_data_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      beat_cnt_q  <= beat_cnt_d;
      busy_q      <= busy_d;
      fifo_wr_q   <= fifo_wr_d;
      fifo_data_q <= fifo_data_d;
    end
  end

  assign fifo_wr   = fifo_wr_q;
  assign fifo_data = fifo_data_q;
  assign grant_id  = grant_id_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios followed by random traffic,
// all checked against a cycle-level behavioural model of arbiter and FIFO.
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int BURST = 4;
  localparam int DEPTH = 8;

  logic           clk = 1'b0;
  logic           rstn;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   ack;
  logic [3:0]     fifo_cnt;
  logic           fifo_full;
  logic           fifo_wr;
  logic [7:0]     fifo_data;
  logic [2:0]     grant_id;
  logic           busy;

  fifo_wr_arbiter #(.N(N), .BURST(BURST), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .req(req), .req_data(req_data), .ack(ack),
    .fifo_cnt(fifo_cnt), .fifo_full(fifo_full), .fifo_wr(fifo_wr),
    .fifo_data(fifo_data), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: FIFO occupancy, arbiter registered view, producer bytes.
  int           m_cnt = 0;
  int           m_rr = 0, m_gid = 0, m_beats = 0;
  bit           m_inburst = 0, m_wr = 0, m_busy = 0;
  byte unsigned m_data = 0;
  byte unsigned pdata [N];
  bit           rand_data = 0;
  int           wr_seen = 0;
  int           gq [$];
  byte unsigned wq [$];
  logic [N-1:0] obs_ack;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: entered and left just after a falling edge.
  task automatic tick(input bit rd);
    int sel;
    bit space;
    logic [N-1:0] eack;
    for (int i = 0; i < N; i++) req_data[8*i +: 8] = pdata[i];
    fifo_cnt  = 4'(m_cnt);
    fifo_full = (m_cnt >= DEPTH);
    #1;
    space = ((m_cnt + int'(m_wr)) < DEPTH) && (m_cnt < DEPTH);
    sel = -1;
    if (rstn) begin
      if (!m_inburst) begin
        if (space)
          for (int k = 0; k < N; k++) begin
            int p;
            p = (m_rr + k) % N;
            if (sel < 0 && req[p]) sel = p;
          end
      end else if (req[m_gid] && space) begin
        sel = m_gid;
      end
    end
    eack = '0;
    if (sel >= 0) eack[sel] = 1'b1;
    chk("ack", 32'(ack), 32'(eack));
    chk("fifo_wr", 32'(fifo_wr), 32'(m_wr));
    chk("fifo_data", 32'(fifo_data), 32'(m_data));
    chk("grant_id", 32'(grant_id), 32'(m_gid));
    chk("busy", 32'(busy), 32'(m_busy));
    obs_ack = ack;
    if (fifo_wr === 1'b1) begin
      wr_seen++;
      wq.push_back(fifo_data);
    end
    for (int i = 0; i < N; i++) if (ack[i] === 1'b1) gq.push_back(i);
    @(posedge clk);
    m_cnt = m_cnt + int'(m_wr) - ((rd && m_cnt > 0) ? 1 : 0);
    chk("no_overflow", 32'(m_cnt <= DEPTH), 32'd1);
    if (!rstn) begin
      m_rr = 0; m_gid = 0; m_beats = 0; m_inburst = 0;
      m_wr = 0; m_busy = 0; m_data = 0;
    end else if (!m_inburst) begin
      if (sel >= 0) begin
        m_wr = 1; m_data = pdata[sel]; m_gid = sel; m_beats = 1;
        if (BURST > 1) begin m_inburst = 1; m_busy = 1; end
        else m_rr = (sel + 1) % N;
      end else m_wr = 0;
    end else begin
      if (sel >= 0) begin
        m_wr = 1; m_data = pdata[sel]; m_beats++;
        if (m_beats == BURST) begin
          m_rr = (m_gid + 1) % N; m_inburst = 0; m_busy = 0;
        end
      end else begin
        m_wr = 0;
        if (!req[m_gid]) begin
          m_rr = (m_gid + 1) % N; m_inburst = 0; m_busy = 0;
        end
      end
    end
    if (sel >= 0) pdata[sel] = rand_data ? 8'($urandom) : 8'(pdata[sel] + 8'd1);
    @(negedge clk);
  endtask

  // Reset for one cycle; the bench FIFO is cleared alongside.
  task automatic do_reset();
    rstn = 1'b0;
    tick(1'b0);
    m_cnt = 0;
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0;
    req  = '0;
    req_data = '0;
    fifo_cnt = 4'd0;
    fifo_full = 1'b0;
    for (int i = 0; i < N; i++) pdata[i] = 8'(8'h10 * (i + 1));
    @(posedge clk);
    @(negedge clk);
    tick(1'b0);
    rstn = 1'b1;

    // Single producer, one full burst of 0x11..0x14.
    pdata[0] = 8'h11;
    req = 4'b0001;
    wq.delete();
    for (int t = 0; t < 4; t++) tick(1'b1);
    req = 4'b0011;
    tick(1'b1);
    chk("rr_after_burst", 32'(obs_ack), 32'h2);
    chk("p1_wr_count", 32'(wq.size()), 32'd4);
    for (int k = 0; k < 4 && k < wq.size(); k++)
      chk("p1_wr_data", 32'(wq[k]), 32'(8'h11 + k));
    req = 4'b0000;
    for (int t = 0; t < 3; t++) tick(1'b1);
    do_reset();

    // All ports requesting with a draining reader.
    req = 4'b1111;
    gq.delete();
    for (int t = 0; t < 100 && gq.size() < 17; t++) tick(1'b1);
    chk("p2_len", 32'(gq.size()), 32'd17);
    for (int k = 0; k < 17 && k < gq.size(); k++)
      chk("p2_grant", 32'(gq[k]), 32'((k / 4) % 4));

    // Drain, then fill the FIFO from port 1 with no reader.
    req = 4'b0000;
    for (int t = 0; t < 30 && (m_cnt > 0 || m_wr); t++) tick(1'b1);
    req = 4'b0010;
    wr_seen = 0;
    for (int t = 0; t < 20; t++) tick(1'b0);
    chk("p3_writes", 32'(wr_seen), 32'd8);
    chk("p3_ack_blocked", 32'(obs_ack), 32'd0);
    chk("p3_cnt_full", 32'(m_cnt), 32'd8);
    chk("p3_grant", 32'(grant_id), 32'd1);
    wr_seen = 0;
    tick(1'b1);
    for (int t = 0; t < 10; t++) tick(1'b0);
    chk("p3_one_more", 32'(wr_seen), 32'd1);

    // Early release by port 2 hands over to port 3 after one bubble.
    do_reset();
    req = 4'b0100;
    tick(1'b1);
    tick(1'b1);
    req = 4'b1000;
    tick(1'b1);
    chk("p5_bubble", 32'(obs_ack), 32'd0);
    tick(1'b1);
    chk("p5_grant3", 32'(obs_ack), 32'h8);
    for (int t = 0; t < 6; t++) tick(1'b1);
    chk("p5_gid", 32'(grant_id), 32'd3);

    // Reset in the middle of a burst.
    do_reset();
    req = 4'b0100;
    for (int t = 0; t < 4; t++) tick(1'b1);
    req = 4'b0010;
    tick(1'b1);
    tick(1'b1);
    rstn = 1'b0;
    tick(1'b1);
    chk("p6_rst_ack", 32'(obs_ack), 32'd0);
    chk("p6_wr", 32'(fifo_wr), 32'd0);
    chk("p6_busy", 32'(busy), 32'd0);
    chk("p6_gid", 32'(grant_id), 32'd0);
    m_cnt = 0;
    rstn = 1'b1;
    req = 4'b1010;
    tick(1'b1);
    chk("p6_restart", 32'(obs_ack), 32'h2);

    // Random traffic with a random reader and occasional resets.
    rand_data = 1;
    for (int t = 0; t < 800; t++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      tick(1'($urandom_range(0, 9) < 6));
      for (int i = 0; i < N; i++) begin
        if (req[i] && obs_ack[i]) req[i] = 1'($urandom_range(0, 1));
        else if (!req[i]) req[i] = ($urandom_range(0, 9) < 4);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
